regdst_pipe: RTL

//  Parametrised successor to the single-cycle destination-register mux.
//  - Selects the write-register address in ID (rt / rd / link register).
//  - Carries {RegWrite, WriteReg} down a STAGES-deep pipeline (ID/EX .. MEM/WB) with bubble, flush and freeze.
//  - Provides per-stage RAW-hazard match flags for the forwarding unit and the hazard unit.

---
 rtl/regdst_pipe.sv | 84 ++++++++
 1 files changed

// File: rtl/regdst_pipe.sv
// Destination-register select in ID plus a STAGES-deep {we, addr} pipeline
// with bubble/freeze control and per-stage RAW match flags for forwarding.
module regdst_pipe #(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [1:0]               RegDst,
  input  logic [REG_AW-1:0]        rt,
  input  logic [REG_AW-1:0]        rd,
  input  logic                     RegWrite_in,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     Freeze,
  input  logic [REG_AW-1:0]        rs_q,
  input  logic [REG_AW-1:0]        rt_q,
  output logic [REG_AW-1:0]        WriteReg_ID,
  output logic [STAGES*REG_AW-1:0] WriteReg_stage,
  output logic [STAGES-1:0]        RegWrite_stage,
  output logic [REG_AW-1:0]        WriteReg_WB,
  output logic                     RegWrite_WB,
  output logic [STAGES-1:0]        hazard_rs,
  output logic [STAGES-1:0]        hazard_rt
);

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

  logic [STAGES-1:0]             r_we;
  logic [STAGES-1:0][REG_AW-1:0] r_addr;
  logic [REG_AW-1:0]             w_sel;
  logic                          w_we_id;
  logic                          w_bubble;

  always_comb begin
    w_sel = '0;
    case (RegDst)
      2'b00:   w_sel = rt;
      2'b01:   w_sel = rd;
      2'b10:   w_sel = LINK_ADDR;
      default: w_sel = '0;
    endcase
  end

  // $0 writes are dropped here so no downstream consumer ever matches on them
  assign w_we_id  = RegWrite_in & (RegDst != 2'b11) & (w_sel != '0);
  assign w_bubble = Stall | Flush;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_we   <= '0;
      r_addr <= '0;
    end else if (!Freeze) begin
      for (int i = 1; i < STAGES; i++) begin
        r_we[i]   <= r_we[i-1];
        r_addr[i] <= r_addr[i-1];
      end
      if (w_bubble) begin
        r_we[0]   <= 1'b0;
        r_addr[0] <= '0;
      end else begin
        r_we[0]   <= w_we_id;
        r_addr[0] <= w_sel;
      end
    end
  end

  always_comb begin
    hazard_rs = '0;
    hazard_rt = '0;
    for (int i = 0; i < STAGES; i++) begin
      hazard_rs[i] = r_we[i] & (r_addr[i] == rs_q) & (rs_q != '0);
      hazard_rt[i] = r_we[i] & (r_addr[i] == rt_q) & (rt_q != '0);
    end
  end

  assign WriteReg_ID    = w_sel;
  assign WriteReg_stage = r_addr;
  assign RegWrite_stage = r_we;
  assign WriteReg_WB    = r_addr[STAGES-1];
  assign RegWrite_WB    = r_we[STAGES-1];

endmodule
